// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types used by the register file, ALU and control.
package cpu_pkg;

  localparam int unsigned DATA_SIZE = 64;
  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned ADDR_SIZE = 5;
  localparam int unsigned ZERO_REG  = 31;

  typedef logic [ADDR_SIZE-1:0] reg_addr_t;
  typedef logic [DATA_SIZE-1:0] data_t;

endpackage

// File: rtl/decoder_5to32.sv
// Binary-to-one-hot write-enable decoder, gated by the global write enable.
module decoder_5to32 #(
  parameter int unsigned AddrWidth = 5,
  localparam int unsigned NumOut   = 1 << AddrWidth
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  logic                 en_i,
  output logic [NumOut-1:0]    onehot_o
);

  // At most one output high, and none when disabled.
  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[addr_i] = 1'b1;
  end

endmodule

// File: rtl/reg64.sv
// Enabled register with synchronous active-low clear; one per architectural register.
module reg64 #(
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_d, q_q;

  // Hold unless enabled.
  always_comb begin
    q_d = q_q;
    if (en_i) q_d = d_i;
  end

  // Clear has priority over a load on the same edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg_file.sv
// 2-read / 1-write architectural register file with a hard-wired zero register
// and optional same-cycle write-to-read forwarding.
module reg_file #(
  parameter int unsigned DATA_SIZE = cpu_pkg::DATA_SIZE,
  parameter int unsigned NUM_REGS  = cpu_pkg::NUM_REGS,
  parameter int unsigned ADDR_SIZE = cpu_pkg::ADDR_SIZE,
  parameter int unsigned ZERO_REG  = cpu_pkg::ZERO_REG,
  parameter bit          BYPASS    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_SIZE-1:0] read_reg1,
  input  logic [ADDR_SIZE-1:0] read_reg2,
  input  logic [ADDR_SIZE-1:0] write_reg,
  input  logic [DATA_SIZE-1:0] write_data,
  input  logic                 reg_write,
  output logic [DATA_SIZE-1:0] read_data1,
  output logic [DATA_SIZE-1:0] read_data2
);

  import cpu_pkg::*;

  localparam logic [ADDR_SIZE-1:0] ZeroAddr = ADDR_SIZE'(ZERO_REG);

  logic [NUM_REGS-1:0]  wr_en;
  logic [DATA_SIZE-1:0] regs [NUM_REGS];

  decoder_5to32 #(
    .AddrWidth (ADDR_SIZE)
  ) u_wr_dec (
    .addr_i   (write_reg),
    .en_i     (reg_write),
    .onehot_o (wr_en)
  );

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
    if (i == ZERO_REG) begin : g_zero
      // No storage: reads of the zero register are constant and its enable is dropped.
      logic unused_zero_en;
      assign unused_zero_en = wr_en[i];
      assign regs[i]        = '0;
    end else begin : g_store
      reg64 #(
        .Width (DATA_SIZE)
      ) u_reg (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .en_i   (wr_en[i]),
        .d_i    (write_data),
        .q_o    (regs[i])
      );
    end
  end

  // A write to the zero register is never forwarded, so it still reads 0.
  logic fwd_ok;
  assign fwd_ok = BYPASS && reg_write && reset_n && (write_reg != ZeroAddr);

  // Read muxes with per-port forwarding of the pending write.
  always_comb begin
    read_data1 = regs[read_reg1];
    read_data2 = regs[read_reg2];
    if (fwd_ok && (write_reg == read_reg1)) read_data1 = write_data;
    if (fwd_ok && (write_reg == read_reg2)) read_data2 = write_data;
  end

endmodule

// File: tb/tb_reg_file.sv
// Randomized self-checking bench for reg_file, running a forwarding and a
// non-forwarding instance side by side against an array-based reference model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  read_reg1, read_reg2, write_reg;
  logic [63:0] write_data;
  logic        reg_write;
  logic [63:0] rd1_byp, rd2_byp, rd1_nob, rd2_nob;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [63:0] model [32];

  always #5 clk = ~clk;

  reg_file #(.BYPASS(1'b1)) u_dut_byp (
    .clk        (clk),
    .reset_n    (reset_n),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reg_write  (reg_write),
    .read_data1 (rd1_byp),
    .read_data2 (rd2_byp)
  );

  reg_file #(.BYPASS(1'b0)) u_dut_nob (
    .clk        (clk),
    .reset_n    (reset_n),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reg_write  (reg_write),
    .read_data1 (rd1_nob),
    .read_data2 (rd2_nob)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Architectural view of a read: X31 is zero, a pending write is visible
  // early only when forwarding is enabled.
  function automatic logic [63:0] exp_read(input logic [4:0] a, input bit fwd);
    if (a == 5'd31) return 64'd0;
    if (fwd && reset_n && reg_write && write_reg == a) return write_data;
    return model[a];
  endfunction

  task automatic check_ports(input string tag);
    #1;
    check({tag, ":byp1"}, rd1_byp, exp_read(read_reg1, 1'b1));
    check({tag, ":byp2"}, rd2_byp, exp_read(read_reg2, 1'b1));
    check({tag, ":nob1"}, rd1_nob, exp_read(read_reg1, 1'b0));
    check({tag, ":nob2"}, rd2_nob, exp_read(read_reg2, 1'b0));
  endtask

  // Advance one clock edge and update the model with what that edge commits.
  task automatic step();
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) model[i] = 64'd0;
    end else if (reg_write && write_reg != 5'd31) begin
      model[write_reg] = write_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [63:0] d);
    reset_n = 1'b1; reg_write = 1'b1; write_reg = a; write_data = d;
    step();
    reg_write = 1'b0;
  endtask

  task automatic sweep_reads(input string tag);
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(31 - i);
      check_ports(tag);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
    reset_n = 1'b0; reg_write = 1'b1; write_reg = 5'd5; write_data = 64'hFFFF;
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    @(negedge clk);
    step();

    // Reset drops the concurrent write; everything reads zero.
    reset_n = 1'b1; reg_write = 1'b0;
    sweep_reads("reset");
    read_reg1 = 5'd5; #1;
    check("x5_after_reset", rd1_byp, 64'd0);

    do_write(5'd3, 64'h0123_4567_89AB_CDEF);
    do_write(5'd7, 64'hDEAD_BEEF_0000_0001);
    read_reg1 = 5'd3; read_reg2 = 5'd7; #1;
    check("x3_read", rd1_byp, 64'h0123_4567_89AB_CDEF);
    check("x7_read", rd2_nob, 64'hDEAD_BEEF_0000_0001);

    // Zero register: pending write not forwarded, committed write ignored.
    reg_write = 1'b1; write_reg = 5'd31; write_data = '1;
    read_reg1 = 5'd31; read_reg2 = 5'd31; #1;
    check("xzr_pending1", rd1_byp, 64'd0);
    check("xzr_pending2", rd2_byp, 64'd0);
    step();
    check("xzr_after1", rd1_byp, 64'd0);
    check("xzr_after2", rd2_nob, 64'd0);

    // Write enable low leaves X10 untouched.
    reg_write = 1'b0; write_reg = 5'd10; write_data = 64'h55;
    step();
    read_reg1 = 5'd10; #1;
    check("we_low_x10", rd1_byp, 64'd0);

    // Forwarding versus registered-only behaviour.
    do_write(5'd4, 64'h1);
    reg_write = 1'b1; write_reg = 5'd4; write_data = 64'h2; read_reg1 = 5'd4; #1;
    check("bypass_before", rd1_byp, 64'h2);
    check("nobypass_before", rd1_nob, 64'h1);
    step();
    check("bypass_after", rd1_byp, 64'h2);
    check("nobypass_after", rd1_nob, 64'h2);
    reg_write = 1'b0;

    // Full sweep of writable registers, then read through both ports.
    for (int i = 0; i < 31; i++) do_write(5'(i), 64'(i) * 64'h0101_0101_0101_0101);
    for (int i = 0; i < 31; i++) begin
      read_reg1 = 5'(i); read_reg2 = 5'(i); #1;
      check("sweep_p1", rd1_byp, 64'(i) * 64'h0101_0101_0101_0101);
      check("sweep_p2", rd2_nob, 64'(i) * 64'h0101_0101_0101_0101);
    end

    // Random traffic with occasional resets.
    for (int n = 0; n < 300; n++) begin
      reset_n    = ($urandom_range(0, 31) != 0);
      reg_write  = $urandom_range(0, 3) != 0;
      write_reg  = 5'($urandom);
      write_data = {$urandom, $urandom};
      read_reg1  = ($urandom_range(0, 2) == 0) ? write_reg : 5'($urandom);
      read_reg2  = ($urandom_range(0, 2) == 0) ? write_reg : 5'($urandom);
      check_ports("rand");
      step();
    end

    // Mid-run reset clears everything.
    reset_n = 1'b0; reg_write = 1'b1; write_reg = 5'd9; write_data = 64'hABCD;
    step();
    reset_n = 1'b1; reg_write = 1'b0;
    sweep_reads("final_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
